multichannel_transition_monitor: RTL and testbench

Parametrised, multi-channel successor to the single-bit transition detector, for the error-resilient pipeline's timing-error sensing.
- Watches CHANNELS data bits and flags edges per channel, filtered by a selectable edge mode.
- On an arm pulse, opens a WINDOW-cycle detection window and accumulates a per-channel error mask.
- Reports a non-empty mask through a valid/ready handshake and keeps a saturating count of reported error windows.

---
 rtl/transition_monitor_pkg.sv | 28 ++
 rtl/edge_detect_ch.sv | 66 ++++++
 rtl/multichannel_transition_monitor.sv | 119 +++++++++++
 tb/tb_multichannel_transition_monitor.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/transition_monitor_pkg.sv
// Shared types for the multichannel transition monitor: FSM state encoding,
// edge-mode encodings and the per-bit edge qualification helper.
package transition_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WINDOW = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

  localparam logic [1:0] MODE_BOTH = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_OFF  = 2'b11;

  // Qualifies a level change from prev to cur against the selected edge mode.
  function automatic logic edge_qual(input logic cur, input logic prev, input logic [1:0] mode);
    logic raw;
    raw = cur ^ prev;
    case (mode)
      MODE_BOTH: edge_qual = raw;
      MODE_RISE: edge_qual = raw & cur;
      MODE_FALL: edge_qual = raw & prev;
      default:   edge_qual = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/edge_detect_ch.sv
// Single-channel registered edge detector with mode qualification and priming.
// Optional 2-sample stability filter when GLITCH_FILTER_EN is defined.
module edge_detect_ch
  import transition_monitor_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       data_in,
  input  logic [1:0] mode,
  output logic       transition
);

  logic r_data_q;
  logic r_transition;
  logic w_level;

`ifdef GLITCH_FILTER_EN
  logic       r_sample;
  logic [1:0] r_prime;

  // r_data_q is the accepted (stable) level; a new level needs two equal samples.
  assign w_level = (data_in == r_sample) ? data_in : r_data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sample     <= 1'b0;
      r_data_q     <= 1'b0;
      r_prime      <= 2'd0;
      r_transition <= 1'b0;
    end else begin
      r_sample     <= data_in;
      r_transition <= 1'b0;
      if (r_prime == 2'd0) begin
        r_data_q <= data_in;
        r_prime  <= 2'd1;
      end else begin
        r_data_q <= w_level;
        if (r_prime == 2'd1) begin
          r_prime <= 2'd2;
        end else begin
          r_transition <= edge_qual(w_level, r_data_q, mode);
        end
      end
    end
  end
`else
  logic r_prime;

  assign w_level = data_in;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data_q     <= 1'b0;
      r_prime      <= 1'b0;
      r_transition <= 1'b0;
    end else begin
      r_data_q     <= data_in;
      r_prime      <= 1'b1;
      r_transition <= r_prime ? edge_qual(w_level, r_data_q, mode) : 1'b0;
    end
  end
`endif

  assign transition = r_transition;

endmodule

// File: rtl/multichannel_transition_monitor.sv
// Multichannel transition monitor: per-channel edge pulses, armed detection
// window, valid/ready error report and saturating report counter.
// Build option GLITCH_FILTER_EN adds a 2-sample filter in each channel.
//
// state     | meaning
// ST_IDLE   | waiting for arm
// ST_WINDOW | accumulating transition into the mask for WINDOW samples
// ST_REPORT | err_valid high, mask held until err_ready
module multichannel_transition_monitor
  import transition_monitor_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int WINDOW   = 4,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] data_in,
  input  logic [1:0]          mode,
  input  logic                arm,
  output logic [CHANNELS-1:0] transition,
  output logic                busy,
  output logic                err_valid,
  output logic [CHANNELS-1:0] err_mask,
  input  logic                err_ready,
  output logic [CNT_W-1:0]    err_count
);

  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  state_e              r_state, w_state_nxt;
  logic [WIN_W-1:0]    r_win_cnt, w_win_cnt_nxt;
  logic [CHANNELS-1:0] r_mask_acc, w_mask_acc_nxt;
  logic [CHANNELS-1:0] r_err_mask, w_err_mask_nxt;
  logic                r_err_valid, w_err_valid_nxt;
  logic [CNT_W-1:0]    r_err_count, w_err_count_nxt;
  logic [CHANNELS-1:0] w_transition;
  logic [CHANNELS-1:0] w_acc_final;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    edge_detect_ch u_edge (
      .clk        (clk),
      .reset      (reset),
      .data_in    (data_in[g]),
      .mode       (mode),
      .transition (w_transition[g])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_win_cnt   <= '0;
      r_mask_acc  <= '0;
      r_err_mask  <= '0;
      r_err_valid <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_win_cnt   <= w_win_cnt_nxt;
      r_mask_acc  <= w_mask_acc_nxt;
      r_err_mask  <= w_err_mask_nxt;
      r_err_valid <= w_err_valid_nxt;
      r_err_count <= w_err_count_nxt;
    end
  end

  // The last window sample is folded in on the same edge that closes the window.
  assign w_acc_final = r_mask_acc | w_transition;

  always_comb begin
    w_state_nxt     = r_state;
    w_win_cnt_nxt   = r_win_cnt;
    w_mask_acc_nxt  = r_mask_acc;
    w_err_mask_nxt  = r_err_mask;
    w_err_valid_nxt = r_err_valid;
    w_err_count_nxt = r_err_count;
    case (r_state)
      ST_IDLE: begin
        if (arm) begin
          w_state_nxt    = ST_WINDOW;
          w_win_cnt_nxt  = WIN_W'(WINDOW - 1);
          w_mask_acc_nxt = '0;
        end
      end
      ST_WINDOW: begin
        w_mask_acc_nxt = w_acc_final;
        if (r_win_cnt == '0) begin
          if (|w_acc_final) begin
            w_state_nxt     = ST_REPORT;
            w_err_mask_nxt  = w_acc_final;
            w_err_valid_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_win_cnt_nxt = r_win_cnt - WIN_W'(1);
        end
      end
      ST_REPORT: begin
        if (err_ready) begin
          w_state_nxt     = ST_IDLE;
          w_err_valid_nxt = 1'b0;
          if (r_err_count != {CNT_W{1'b1}}) begin
            w_err_count_nxt = r_err_count + CNT_W'(1);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign transition = w_transition;
  assign busy       = (r_state != ST_IDLE);
  assign err_valid  = r_err_valid;
  assign err_mask   = r_err_mask;
  assign err_count  = r_err_count;

endmodule

// File: tb/tb_multichannel_transition_monitor.sv
// Bench for multichannel_transition_monitor (CHANNELS=8, WINDOW=4, CNT_W=2).
// Also meaningful with GLITCH_FILTER_EN defined; the reference model follows it.
module tb_multichannel_transition_monitor;

  localparam int CH = 8;
  localparam int W  = 4;
  localparam int CW = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [CH-1:0] data_in = '0;
  logic [1:0]    mode = 2'b00;
  logic          arm = 1'b0;
  logic          err_ready = 1'b0;
  logic [CH-1:0] transition;
  logic          busy;
  logic          err_valid;
  logic [CH-1:0] err_mask;
  logic [CW-1:0] err_count;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state: edges since reset release, expected outputs.
  int            n_edge;
  logic [CH-1:0] m_prev, m_lvl, m_samp, m_tr, m_acc, m_mask;
  logic          m_busy, m_inwin, m_valid;
  int            m_left, m_count;

  multichannel_transition_monitor #(
    .CHANNELS (CH),
    .WINDOW   (W),
    .CNT_W    (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .mode       (mode),
    .arm        (arm),
    .transition (transition),
    .busy       (busy),
    .err_valid  (err_valid),
    .err_mask   (err_mask),
    .err_ready  (err_ready),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [CH-1:0] qual(input logic [CH-1:0] from_v, input logic [CH-1:0] to_v,
                                         input logic [1:0] md);
    case (md)
      2'b00:   return from_v ^ to_v;
      2'b01:   return (from_v ^ to_v) & to_v;
      2'b10:   return (from_v ^ to_v) & from_v;
      default: return '0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("transition", 32'(transition), 32'(m_tr));
    check("busy", 32'(busy), 32'(m_busy));
    check("err_valid", 32'(err_valid), 32'(m_valid));
    check("err_mask", 32'(err_mask), 32'(m_mask));
    check("err_count", 32'(err_count), 32'(m_count));
  endtask

  task automatic model_reset();
    n_edge = 0;
    m_prev = '0; m_lvl = '0; m_samp = '0; m_tr = '0; m_acc = '0; m_mask = '0;
    m_busy = 1'b0; m_inwin = 1'b0; m_valid = 1'b0; m_left = 0; m_count = 0;
  endtask

  task automatic model_edge();
`ifdef GLITCH_FILTER_EN
    logic [CH-1:0] same, nl;
`endif
    n_edge++;
    if (!m_busy) begin
      if (arm) begin
        m_busy = 1'b1; m_inwin = 1'b1; m_left = W; m_acc = '0;
      end
    end else if (m_inwin) begin
      m_acc |= m_tr;
      m_left--;
      if (m_left == 0) begin
        m_inwin = 1'b0;
        if (m_acc != '0) begin
          m_valid = 1'b1; m_mask = m_acc;
        end else begin
          m_busy = 1'b0;
        end
      end
    end else if (err_ready) begin
      m_valid = 1'b0; m_busy = 1'b0;
      if (m_count < CNT_MAX) m_count++;
    end
`ifdef GLITCH_FILTER_EN
    same = ~(data_in ^ m_samp);
    nl   = (m_lvl & ~same) | (data_in & same);
    if (n_edge == 1) begin
      m_lvl = data_in; m_tr = '0;
    end else begin
      m_tr  = (n_edge == 2) ? '0 : qual(m_lvl, nl, mode);
      m_lvl = nl;
    end
    m_samp = data_in;
`else
    m_tr   = (n_edge == 1) ? '0 : qual(m_prev, data_in, mode);
    m_prev = data_in;
`endif
  endtask

  // Inputs change at negedge; model steps at posedge; outputs checked at next negedge.
  task automatic cyc(input logic [CH-1:0] d, input logic [1:0] m, input logic a, input logic r);
    data_in = d; mode = m; arm = a; err_ready = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic async_reset();
    reset = 1'b0;
    #1;
    model_reset();
    check("async_rst_busy", 32'(busy), 32'd0);
    check_all();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  int exp_cnt[5] = '{1, 2, 3, 3, 3};

  initial begin
    model_reset();
    data_in = 8'hFF;
    @(negedge clk);
    @(negedge clk);
    check_all();
    reset = 1'b1;

    // Data held high through reset release: no spurious edges.
    repeat (6) cyc(8'hFF, 2'b00, 1'b0, 1'b0);
    check("prime_ff", 32'(transition), 32'd0);
    repeat (3) cyc(8'h00, 2'b00, 1'b0, 1'b0);

    // Edge modes.
    cyc(8'h05, 2'b00, 1'b0, 1'b0);
`ifndef GLITCH_FILTER_EN
    check("both_rise", 32'(transition), 32'h05);
`endif
    cyc(8'h05, 2'b00, 1'b0, 1'b0);
`ifndef GLITCH_FILTER_EN
    check("one_cycle", 32'(transition), 32'h00);
`endif
    repeat (2) cyc(8'h00, 2'b10, 1'b0, 1'b0);
    cyc(8'h05, 2'b10, 1'b0, 1'b0);
    repeat (2) cyc(8'h05, 2'b10, 1'b0, 1'b0);
    cyc(8'h00, 2'b10, 1'b0, 1'b0);
`ifndef GLITCH_FILTER_EN
    check("fall_only", 32'(transition), 32'h05);
`endif
    repeat (3) cyc(8'h00, 2'b01, 1'b0, 1'b0);
    repeat (2) cyc(8'h00, 2'b00, 1'b0, 1'b0);

    // Window with ch1 then ch6 toggling; report held until err_ready.
    cyc(8'h00, 2'b00, 1'b1, 1'b0);
    cyc(8'h02, 2'b00, 1'b0, 1'b0);
    cyc(8'h02, 2'b00, 1'b0, 1'b0);
    cyc(8'h42, 2'b00, 1'b0, 1'b0);
    cyc(8'h42, 2'b00, 1'b0, 1'b0);
`ifndef GLITCH_FILTER_EN
    check("mask_42", 32'(err_mask), 32'h42);
`endif
    for (int k = 0; k < 3; k++) begin
      cyc(8'h42, 2'b00, 1'b0, 1'b0);
`ifndef GLITCH_FILTER_EN
      check("mask_hold", 32'(err_mask), 32'h42);
`endif
    end
    cyc(8'h42, 2'b00, 1'b0, 1'b1);
    check("accept_busy", 32'(busy), 32'd0);
    check("accept_cnt", 32'(err_count), 32'd1);

    // Quiet window with arm held high throughout.
    repeat (5) cyc(8'h42, 2'b00, 1'b1, 1'b0);
    check("quiet_valid", 32'(err_valid), 32'd0);
    repeat (5) cyc(8'h42, 2'b00, 1'b0, 1'b0);

    // arm during REPORT and on the accepting edge is dropped.
    cyc(8'h42, 2'b00, 1'b1, 1'b0);
    cyc(8'h43, 2'b00, 1'b0, 1'b0);
    repeat (4) cyc(8'h43, 2'b00, 1'b1, 1'b0);
    cyc(8'h43, 2'b00, 1'b1, 1'b1);
    cyc(8'h43, 2'b00, 1'b0, 1'b0);
    check("no_queue", 32'(busy), 32'd0);

    // Asynchronous reset mid-window, then mid-report.
    cyc(8'h43, 2'b00, 1'b1, 1'b0);
    cyc(8'h41, 2'b00, 1'b0, 1'b0);
    async_reset();
    repeat (3) cyc(8'h41, 2'b00, 1'b0, 1'b0);
    cyc(8'h41, 2'b00, 1'b1, 1'b0);
    cyc(8'h40, 2'b00, 1'b0, 1'b0);
    repeat (4) cyc(8'h40, 2'b00, 1'b0, 1'b0);
    check("pre_rst_valid", 32'(err_valid), 32'd1);
    async_reset();
    repeat (3) cyc(8'h40, 2'b00, 1'b0, 1'b0);

    // Counter saturation at 2^CNT_W-1.
    for (int k = 0; k < 5; k++) begin
      cyc(data_in, 2'b00, 1'b1, 1'b0);
      cyc(data_in ^ 8'h01, 2'b00, 1'b0, 1'b0);
      repeat (4) cyc(data_in, 2'b00, 1'b0, 1'b0);
      cyc(data_in, 2'b00, 1'b0, 1'b1);
      check("sat_cnt", 32'(err_count), 32'(exp_cnt[k]));
    end

`ifdef GLITCH_FILTER_EN
    // One-cycle pulse on ch0 is dropped; a two-cycle level gives a pulse 2 cycles later.
    repeat (3) cyc(8'h00, 2'b00, 1'b0, 1'b0);
    cyc(8'h01, 2'b00, 1'b0, 1'b0);
    check("glitch_a", 32'(transition), 32'd0);
    cyc(8'h00, 2'b00, 1'b0, 1'b0);
    check("glitch_b", 32'(transition), 32'd0);
    cyc(8'h00, 2'b00, 1'b0, 1'b0);
    check("glitch_c", 32'(transition), 32'd0);
    cyc(8'h01, 2'b00, 1'b0, 1'b0);
    check("level_a", 32'(transition), 32'd0);
    cyc(8'h01, 2'b00, 1'b0, 1'b0);
    check("level_b", 32'(transition), 32'h01);
    cyc(8'h01, 2'b00, 1'b0, 1'b0);
`endif

    // Randomized traffic against the reference model.
    for (int k = 0; k < 400; k++) begin
      logic [CH-1:0] d;
      d = ($urandom_range(0, 2) == 0) ? data_in : CH'($urandom);
      cyc(d, 2'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
